// File: rtl/control_sequencer.sv
// control_sequencer: table-driven instruction control sequencer.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   instr_valid/instr_ready  - instruction handshake, op_code/func_code form the table address
//   cfg_we/cfg_addr/cfg_data - control table write port ({valid, control word}), cfg_busy blocks it
//   ALU_OP/ALU_Src/Branch/MEM_TR - decoded control fields, held from EXEC through FIN
//   mem_req/mem_rd/mem_wr/mem_ack - memory handshake during MEM
//   reg_we/pc_we/done/err    - completion strobes and error pulse
module control_sequencer #(
    parameter int OP_W    = 6,
    parameter int FN_W    = 6,
    parameter int ALUOP_W = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_valid,
    output logic                    instr_ready,
    input  logic [OP_W-1:0]         op_code,
    input  logic [FN_W-1:0]         func_code,
    input  logic                    cfg_we,
    input  logic [OP_W+FN_W-1:0]    cfg_addr,
    input  logic [ALUOP_W+6:0]      cfg_data,
    output logic                    cfg_busy,
    output logic [ALUOP_W-1:0]      ALU_OP,
    output logic                    ALU_Src,
    output logic                    Branch,
    output logic                    MEM_TR,
    output logic                    mem_req,
    output logic                    mem_rd,
    output logic                    mem_wr,
    input  logic                    mem_ack,
    output logic                    reg_we,
    output logic                    pc_we,
    output logic                    done,
    output logic                    err
);
    localparam int AW    = OP_W + FN_W;
    localparam int CW    = ALUOP_W + 6;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {INIT, IDLE, DECODE, EXEC, MEM, FIN} state_t;

    state_t            state, ns;
    logic [CW:0]       tbl [2**AW];
    logic [AW-1:0]     idx, idx_d, addr_q, addr_d, tbl_wa;
    logic [CW:0]       cw_q, cw_d, tbl_wd;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              err_d, act, tbl_we;

    // Single write port shared by the INIT zeroing sweep and configuration writes;
    // cfg_busy is low only in IDLE, so the two never collide.
    assign tbl_we = !rst && (state == INIT || (cfg_we && !cfg_busy));
    assign tbl_wa = (state == INIT) ? idx : cfg_addr;
    assign tbl_wd = (state == INIT) ? '0 : cfg_data;

    always_ff @(posedge clk)
        if (tbl_we)
            tbl[tbl_wa] <= tbl_wd;

    always_comb begin
        ns     = state;
        idx_d  = idx;
        addr_d = addr_q;
        cw_d   = cw_q;
        cnt_d  = cnt;
        err_d  = 1'b0;
        case (state)
            INIT: begin
                idx_d = idx + 1'b1;
                if (&idx)
                    ns = IDLE;
            end
            IDLE: if (instr_valid && instr_ready) begin
                addr_d = {op_code, func_code};
                ns     = DECODE;
            end
            DECODE: begin
                // A same-cycle cfg write in IDLE landed on the accept edge, so this read sees it.
                cw_d  = tbl[addr_q];
                ns    = cw_d[CW] ? EXEC : IDLE;
                err_d = !cw_d[CW];
            end
            EXEC: begin
                cnt_d = '0;
                ns    = (cw_q[3] || cw_q[2]) ? MEM : FIN;
            end
            MEM: begin
                if (mem_ack)
                    ns = FIN;
                else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    ns    = IDLE;
                    err_d = 1'b1;
                end else
                    cnt_d = cnt + 1'b1;
            end
            FIN:     ns = IDLE;
            default: ns = INIT;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    assign act = (ns == EXEC) || (ns == MEM) || (ns == FIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            idx         <= '0;
            addr_q      <= '0;
            cw_q        <= '0;
            cnt         <= '0;
            instr_ready <= 1'b0;
            cfg_busy    <= 1'b1;
            ALU_OP      <= '0;
            ALU_Src     <= 1'b0;
            Branch      <= 1'b0;
            MEM_TR      <= 1'b0;
            mem_req     <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            reg_we      <= 1'b0;
            pc_we       <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= ns;
            idx         <= idx_d;
            addr_q      <= addr_d;
            cw_q        <= cw_d;
            cnt         <= cnt_d;
            instr_ready <= ns == IDLE;
            cfg_busy    <= ns != IDLE;
            ALU_OP      <= act ? cw_d[CW-1:6] : '0;
            ALU_Src     <= act && cw_d[5];
            Branch      <= act && cw_d[4];
            MEM_TR      <= act && cw_d[1];
            mem_req     <= ns == MEM;
            mem_rd      <= (ns == MEM) && cw_d[3];
            mem_wr      <= (ns == MEM) && cw_d[2] && !cw_d[3];
            reg_we      <= (ns == FIN) && cw_d[0];
            pc_we       <= ns == FIN;
            done        <= ns == FIN;
            err         <= err_d;
        end
    end
endmodule
